scc_channel_mixer: RTL and testbench

Time-division channel sequencer and mixer for the 6-channel wave table sound core.
- Drives the 3-bit channel index into the combinational per-channel register selector.
- Consumes that selector's outputs for the addressed channel: current wave sample, volume and key flag.
- Scales each sample by its volume and accumulates all 6 channels into one signed mix sample per round, for the output/DAC stage.

---
 rtl/scc_channel_mixer.sv | 106 ++++++++++
 tb/tb_scc_channel_mixer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scc_channel_mixer.sv
// rtl/scc_channel_mixer.sv - time-division 6-channel sequencer, volume scaler and mixer
//
// Walks a slot counter 0..5 through the per-channel register selector, scales
// each returned wave sample by its volume (zero when the key is off) and sums
// the six contributions of one round into a signed mix sample.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      slot-advance strobe; one channel is processed per enabled cycle
//   active      channel index 0..5 presented to the selector
//   sel_wave    signed wave sample of channel `active`
//   sel_volume  unsigned volume of channel `active`
//   sel_key     key-on of channel `active`
//   mix_out     signed mixed sample, held between rounds
//   mix_valid   one-cycle pulse when mix_out updates
//   round_busy  high while a round is partially accumulated

module scc_channel_mixer #(
  parameter int wave_bits = 8,
  parameter int vol_bits  = 4,
  parameter int mix_bits  = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  output logic [2:0]                  active,
  input  logic signed [wave_bits-1:0] sel_wave,
  input  logic [vol_bits-1:0]         sel_volume,
  input  logic                        sel_key,
  output logic signed [mix_bits-1:0]  mix_out,
  output logic                        mix_valid,
  output logic                        round_busy
);

  // Product width: signed wave times volume widened by one zero bit.
  localparam int PW = wave_bits + vol_bits + 1;

  logic signed [PW-1:0]       wave_ext;
  logic signed [PW-1:0]       vol_ext;
  logic signed [PW-1:0]       mul;
  logic signed [PW-1:0]       prod;
  logic                       p_valid;
  logic                       p_first;
  logic                       p_last;
  logic signed [mix_bits-1:0] acc;
  logic signed [mix_bits-1:0] prod_ext;
  logic signed [mix_bits-1:0] acc_next;

  assign wave_ext = {{(PW - wave_bits){sel_wave[wave_bits-1]}}, sel_wave};
  assign vol_ext  = {{(PW - vol_bits){1'b0}}, sel_volume};
  assign mul      = wave_ext * vol_ext;

  assign prod_ext = {{(mix_bits - PW){prod[PW-1]}}, prod};
  // Slot 0 restarts the sum, so no separate clear of the accumulator is needed.
  assign acc_next = p_first ? prod_ext : acc + prod_ext;

  // Slot counter and stage 1: capture the scaled sample of the addressed channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 3'd0;
      prod    <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (enable) begin
      active  <= (active == 3'd5) ? 3'd0 : active + 3'd1;
      prod    <= sel_key ? mul : '0;
      p_valid <= 1'b1;
      p_first <= (active == 3'd0);
      p_last  <= (active == 3'd5);
    end else begin
      p_valid <= 1'b0;
    end
  end

  // Stage 2: accumulate and publish the completed round.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (p_valid) begin
        acc <= acc_next;
        if (p_last) begin
          mix_out   <= acc_next;
          mix_valid <= 1'b1;
        end
      end
    end
  end

  // A slot-0 capture can coincide with the previous round's final update in
  // back-to-back operation; the new round must then keep busy asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_busy <= 1'b0;
    end else begin
      if (p_valid && p_last) round_busy <= 1'b0;
      if (enable && active == 3'd0) round_busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scc_channel_mixer.sv
// tb/tb_scc_channel_mixer.sv - self-checking bench for scc_channel_mixer

module tb_scc_channel_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               enable;
  logic [2:0]         active;
  logic signed [7:0]  sel_wave;
  logic [3:0]         sel_volume;
  logic               sel_key;
  logic signed [14:0] mix_out;
  logic               mix_valid;
  logic               round_busy;

  // Per-channel register file standing in for the selector.
  int ch_wave [8];
  int ch_vol  [8];
  bit ch_key  [8];

  assign sel_wave   = 8'(ch_wave[active]);
  assign sel_volume = 4'(ch_vol[active]);
  assign sel_key    = ch_key[active];

  scc_channel_mixer #(.wave_bits(8), .vol_bits(4), .mix_bits(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .active     (active),
    .sel_wave   (sel_wave),
    .sel_volume (sel_volume),
    .sel_key    (sel_key),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .round_busy (round_busy)
  );

  // Reference model: running round sum plus a two-cycle delivery delay.
  int m_active;
  int m_sum;
  int m_mix;
  bit m_valid;
  bit d_v;
  int d_val;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit r; bit e; int w; int v; bit k;
    int a; bit mv; int mix; bit busy;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_all(input int w, input int v, input bit k);
    for (int i = 0; i < 8; i++) begin
      ch_wave[i] = w; ch_vol[i] = v; ch_key[i] = k;
    end
  endtask

  task automatic step(input bit r, input bit e);
    int c;
    reset  = r;
    enable = e;
    c = ch_key[m_active] ? ch_wave[m_active] * ch_vol[m_active] : 0;
    @(posedge clk);
    if (r) begin
      m_active = 0; m_sum = 0; m_mix = 0; m_valid = 0; d_v = 0; d_val = 0;
    end else begin
      m_valid = d_v;
      if (d_v) m_mix = d_val;
      d_v = 0;
      if (e) begin
        m_sum = (m_active == 0) ? c : m_sum + c;
        if (m_active == 5) begin
          d_v = 1; d_val = m_sum;
        end
        m_active = (m_active + 1) % 6;
      end
    end
    #1;
    chk("active", int'(active), m_active);
    chk("mix_valid", int'(mix_valid), int'(m_valid));
    chk("mix_out", int'(mix_out), m_mix);
    chk("round_busy", int'(round_busy), int'((m_active != 0) || d_v));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    set_all(0, 0, 0);
    m_active = 0; m_sum = 0; m_mix = 0; m_valid = 0; d_v = 0; d_val = 0;

    // Reset, idle, then one full-scale positive round.
    for (int i = 0; i < 13; i++) begin
      tbl[i] = '{r:(i < 3), e:(i >= 5), w:127, v:15, k:1,
                 a:0, mv:0, mix:0, busy:0};
    end
    for (int i = 5; i < 13; i++) begin
      tbl[i].a    = (i - 4) % 6;
      tbl[i].busy = 1;
    end
    tbl[11].mv = 1; tbl[11].mix = 11430;
    tbl[12].mix = 11430;

    for (int i = 0; i < 13; i++) begin
      set_all(tbl[i].w, tbl[i].v, tbl[i].k);
      step(tbl[i].r, tbl[i].e);
      chk("tbl_active", int'(active), tbl[i].a);
      chk("tbl_mix_valid", int'(mix_valid), int'(tbl[i].mv));
      chk("tbl_mix_out", int'(mix_out), tbl[i].mix);
      chk("tbl_round_busy", int'(round_busy), int'(tbl[i].busy));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // Idle after reset leaves everything at zero.
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("idle_active", int'(active), 0);

    // Full-scale negative round.
    set_all(-128, 15, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("neg_valid", int'(mix_valid), 1);
    chk("neg_mix", int'(mix_out), -11520);

    // Only channel 2 keyed on.
    set_all(100, 15, 0);
    ch_wave[2] = 10; ch_vol[2] = 3; ch_key[2] = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("key2_valid", int'(mix_valid), 1);
    chk("key2_mix", int'(mix_out), 30);

    // Enable one cycle in three, selector values scrambled while idle.
    set_all(0, 1, 1);
    for (int i = 0; i < 6; i++) ch_wave[i] = i + 1;
    for (int i = 0; i < 17; i++) begin
      if (i % 3 != 0) ch_wave[7] = int'($urandom_range(0, 99));
      step(1'b0, (i % 3) == 0);
    end
    chk("sparse_valid", int'(mix_valid), 1);
    chk("sparse_mix", int'(mix_out), 21);
    step(1'b0, 1'b0);
    chk("sparse_pulse", int'(mix_valid), 0);

    // Reset mid-round at slot 3, then a clean round.
    set_all(50, 7, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("mid_active", int'(active), 3);
    step(1'b1, 1'b0);
    chk("abort_mix", int'(mix_out), 0);
    chk("abort_busy", int'(round_busy), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("restart_mix", int'(mix_out), 2100);

    // Reset right after slot 5 drops the product in flight.
    set_all(-3, 2, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("inflight_valid", int'(mix_valid), 0);
    chk("inflight_mix", int'(mix_out), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 6; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          ch_wave[c] = int'($urandom_range(0, 255)) - 128;
          ch_vol[c]  = int'($urandom_range(0, 15));
          ch_key[c]  = ($urandom_range(0, 3) != 0);
        end
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
